lsu_ctrl: RTL

- Load/store unit between the execute stage and the word-wide data RAM; the RAM has no byte enables, 32-bit write, combinational read, word index = addr>>2.
- Accepts one RISC-V load/store request per handshake and checks alignment.
- Sub-word loads: extracts and sign/zero-extends the addressed lane.
- Sub-word stores: performs read-modify-write so the RAM only ever sees full words.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 38 +++
 rtl/lsu_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM encoding,
// lane geometry and the request fault classification.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  // Lane geometry: byte lane = addr[1:0], half lane = addr[1].
  localparam int BYTE_BITS = 8;
  localparam int HALF_BITS = 16;

  function automatic logic is_badop(input logic we, input logic [2:0] f3);
    if (we) return (f3 >= 3'b011);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Only meaningful for funct3 values that passed is_badop.
  function automatic logic is_misalign(input logic [2:0] f3, input logic [1:0] a);
    if (f3[1:0] == 2'b01) return a[0];
    if (f3[1:0] == 2'b10) return (a != 2'b00);
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and
// read-modify-write merge of sub-word store data into a full RAM word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [BYTE_BITS-1:0] byte_v;
  logic [HALF_BITS-1:0] half_v;

  always_comb begin
    byte_v = word_i[{lane_i, 3'b000} +: BYTE_BITS];
    half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];

    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_o = {24'd0, byte_v};
      F3_H:    load_o = {{16{half_v[15]}}, half_v};
      F3_HU:   load_o = {16'd0, half_v};
      default: load_o = word_i;
    endcase

    store_o = word_i;
    case (funct3_i)
      F3_B:    store_o[{lane_i, 3'b000} +: BYTE_BITS] = wdata_i[7:0];
      F3_H:    store_o[{lane_i[1], 4'b0000} +: HALF_BITS] = wdata_i[15:0];
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller for a word-wide RAM without byte enables: one request
// per handshake, alignment/opcode faulting, and read-modify-write for sub-word stores.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [31:0]           o_resp_rdata,
  output logic                  o_resp_misalign,
  output logic                  o_resp_badop,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata,
  output logic [1:0]            o_dbg_state
);

  // Handshakes: a request transfers on a posedge where i_req_valid && o_req_ready;
  // a response transfers on a posedge where o_resp_valid && i_resp_ready.

  lsu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  we_q, we_d;
  logic [31:0]           word_q, word_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  misalign_q, misalign_d;
  logic                  badop_q, badop_d;

  logic [31:0] align_word;
  logic [31:0] load_val;
  logic [31:0] store_word;

  // During ACCESS the RAM word is live on i_mem_rdata; afterwards it lives in word_q.
  assign align_word = (state_q == ACCESS) ? i_mem_rdata : word_q;

  lsu_align u_align (
    .funct3_i (funct3_q),
    .lane_i   (addr_q[1:0]),
    .word_i   (align_word),
    .wdata_i  (wdata_q),
    .load_o   (load_val),
    .store_o  (store_word)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    we_d       = we_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    badop_d    = badop_q;

    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          addr_d     = i_req_addr;
          wdata_d    = i_req_wdata;
          funct3_d   = i_req_funct3;
          we_d       = i_req_we;
          rdata_d    = 32'd0;
          badop_d    = is_badop(i_req_we, i_req_funct3);
          misalign_d = !badop_d && is_misalign(i_req_funct3, i_req_addr[1:0]);
          state_d    = (badop_d || misalign_d) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        word_d = i_mem_rdata;
        if (we_q) begin
          state_d = WRITE;
        end else begin
          rdata_d = load_val;
          state_d = RESP;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (i_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      word_q     <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      badop_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      we_q       <= we_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      badop_q    <= badop_d;
    end
  end

  // Decoded straight from state_q so the async reset kills a pending write at once.
  assign o_req_ready     = (state_q == IDLE);
  assign o_resp_valid    = (state_q == RESP);
  assign o_mem_we        = (state_q == WRITE);
  assign o_mem_addr      = addr_q;
  assign o_mem_wdata     = store_word;
  assign o_resp_rdata    = rdata_q;
  assign o_resp_misalign = misalign_q;
  assign o_resp_badop    = badop_q;
  assign o_dbg_state     = state_q;

endmodule
